// File: rtl/ifid_fetch_unit.sv
// Fetch-side producer for the IF/ID register: pulls a three-byte instruction over an
// 8-bit read port, presents it with its PC and pulses ifid_en when the decoder accepts it.
module ifid_fetch_unit #(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [AW-1:0] imem_rdata,
  input  logic          imem_ack,
  input  logic          stall,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          ifid_en,
  output logic [AW-1:0] fetch_write_addr,
  output logic [AW-1:0] fetch_read_addr,
  output logic [AW-1:0] fetch_next_pc,
  output logic [AW-1:0] fetch_pc,
  output logic          fetch_valid
);

  typedef enum logic [1:0] {F0, F1, F2, PRESENT} state_t;

  state_t        state, state_next;
  logic [AW-1:0] pc, pc_next;
  logic          valid_next;
  logic          ack_take;

  assign imem_req = (state != PRESENT);
  assign ifid_en  = fetch_valid & ~stall & ~redirect;
  // A byte returned in a redirect cycle belongs to the discarded fetch.
  assign ack_take = imem_req & imem_ack & ~redirect;

  always_comb begin
    unique case (state)
      F1:      imem_addr = pc + AW'(1);
      F2:      imem_addr = pc + AW'(2);
      default: imem_addr = pc;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_next = state;
    pc_next    = pc;
    valid_next = fetch_valid;
    if (redirect) begin
      state_next = F0;
      pc_next    = redirect_pc;
      valid_next = 1'b0;
    end else begin
      unique case (state)
        F0: if (imem_ack) state_next = F1;
        F1: if (imem_ack) state_next = F2;
        F2: if (imem_ack) begin
          state_next = PRESENT;
          valid_next = 1'b1;
        end
        PRESENT: if (ifid_en) begin
          state_next = F0;
          pc_next    = pc + AW'(3);
          valid_next = 1'b0;
        end
        default: state_next = F0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= F0;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      fetch_valid <= valid_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_write_addr <= '0;
      fetch_read_addr  <= '0;
      fetch_next_pc    <= '0;
      fetch_pc         <= '0;
    end else if (ack_take) begin
      unique case (state)
        F0: fetch_write_addr <= imem_rdata;
        F1: fetch_read_addr  <= imem_rdata;
        F2: begin
          fetch_next_pc <= imem_rdata;
          fetch_pc      <= pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ifid_fetch_unit.md
Name: ifid_fetch_unit

Overview:
- Fetch-side producer for the IF/ID pipeline register.
- Reads one three-byte instruction (write-address field, read-address field, branch-target field) over an 8-bit instruction-memory read port, one byte per handshake.
- Assembles the bytes, presents them with the instruction's PC, and drives the IF/ID register's enable.
- Handles downstream stall and redirect (taken branch) from later stages.

Parameters:
- AW, 8, address/data width of PC, memory address and instruction fields.
- RESET_PC, 8'h00, PC loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  memory read request.
- imem_addr  out  AW  byte address requested; valid while imem_req=1.
- imem_rdata  in  AW  read byte; valid in the cycle imem_ack=1.
- imem_ack  in  1  single-cycle completion; may be asserted in the same cycle as imem_req.
- stall  in  1  downstream not ready; IF/ID must hold.
- redirect  in  1  taken branch; discard current fetch.
- redirect_pc  in  AW  new PC; sampled when redirect=1.
- ifid_en  out  1  load strobe for the IF/ID register.
- fetch_write_addr  out  AW  instruction byte 0.
- fetch_read_addr  out  AW  instruction byte 1.
- fetch_next_pc  out  AW  instruction byte 2 (branch target).
- fetch_pc  out  AW  address of the instruction's byte 0.
- fetch_valid  out  1  instruction assembled and presented.

Behaviour:
- Reset:
  - Asynchronous on rst_n=0; takes effect immediately, including mid-handshake.
  - pc=RESET_PC, state=F0, fetch_valid=0, all field registers and fetch_pc=0.
  - imem_req goes to 1 in the first cycle after release (combinational from state).
- States: F0, F1, F2, PRESENT.
- F0/F1/F2 (fetching):
  - imem_req=1; imem_addr = pc+0, pc+1, pc+2 respectively, modulo 2^AW (0xFE+2 -> 0x00).
  - On imem_ack: latch imem_rdata into field 0/1/2 and advance F0->F1->F2->PRESENT.
  - Without ack: hold state, with imem_addr stable.
- PRESENT:
  - imem_req=0; fetch_valid=1; fields and fetch_pc=pc held stable.
  - ifid_en = fetch_valid & ~stall & ~redirect (combinational).
  - When ifid_en=1, at the next edge: pc <= pc+3 (mod 2^AW), state <= F0, fetch_valid <= 0.
  - While stall=1: hold everything indefinitely.
- imem_ack outside F0-F2 is ignored.
- Redirect (highest priority, any state):
  - Next edge: pc <= redirect_pc, state <= F0, fetch_valid <= 0.
  - Partially assembled bytes are discarded; an imem_ack in the same cycle is ignored.
  - ifid_en=0 in the redirect cycle, even if PRESENT & ~stall.
  - Dropping imem_req mid-handshake is legal; the instruction memory is a stateless read port.
- redirect together with stall: redirect wins.
- Timing with zero-wait memory (ack same cycle):
  - Fields visible in cycle 4 after F0 entry.
  - Throughput is 1 instruction per 4 cycles.
  - Each memory wait cycle adds 1.
- ifid_en is never asserted while fetch_valid=0.
- All registered outputs change only on clk or on the rst_n assertion.

Test Plan:
1. Reset release, RESET_PC=0, zero-wait memory returning bytes 0x10,0x20,0x05 -> imem_addr 0,1,2 on consecutive cycles; cycle 4 fetch_valid=1, fields 0x10/0x20/0x05, fetch_pc=0, ifid_en=1; next request addr 3.
2. Same, stall=1 for 5 cycles in PRESENT -> fields and fetch_pc stable, ifid_en=0, imem_req=0 throughout; ifid_en pulses once on stall release.
3. Wait states: ack delayed 2 cycles per byte -> imem_addr held stable until ack; fetch_valid rises 9 cycles after F0 entry.
4. Redirect to 0x40 during F1 with simultaneous ack -> that byte discarded; next cycle imem_addr=0x40 in F0; presented fetch_pc=0x40.
5. Wrap: pc=0xFE -> addresses 0xFE,0xFF,0x00; after ifid_en, next fetch at 0x01.
6. rst_n asserted in PRESENT with stall=1 -> fetch_valid=0 and ifid_en=0 immediately (no clock edge); after release, fetch restarts at RESET_PC.
